config_register_file: RTL and testbench
=======================================

Name: config_register_file

Overview:
Responder end of the address/data/valid/ack link driven by the frame address decoder.
- Captures each 4-bit address + 4-bit data command into a bank of 4-bit configuration registers.
- Returns a one-cycle ack pulse and a per-write update strobe.
- The flattened register bank feeds the VGA timing/colour logic, so all config writes from the UART path land here.

Parameters:
NUM_REGS, 16, number of implemented 4-bit registers (1..16); addresses >= NUM_REGS are unmapped.
RELEASE_TIMEOUT, 4, max cycles spent waiting for valid to drop after ack before returning to IDLE (1..15).
RESET_VALUE, 4'h0, reset/clear value of every register.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears all state immediately
address  input  4  register address from decoder
data  input  4  write data from decoder
valid  input  1  command valid from decoder; may stay high for several cycles
ack  output  1  one-cycle accept pulse back to decoder, registered
regs  output  4*NUM_REGS  flattened bank; register i at bits [4*i+3:4*i], registered
upd_strobe  output  1  one-cycle pulse, high in the cycle a mapped register takes its new value
upd_addr  output  4  address of last write attempt (mapped or not); holds between writes
err  output  1  one-cycle pulse when a write targets an unmapped address

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE, release counter=0.
  - ack=0, upd_strobe=0, err=0, upd_addr=0.
  - All regs=RESET_VALUE.
- FSM states: IDLE, WRITE, ACK, RELEASE.
- IDLE:
  - If valid=1 at a rising edge, latch address and data into internal capture registers; next state WRITE.
  - Inputs are ignored otherwise.
- WRITE (one cycle):
  - If captured address < NUM_REGS: reg[addr] <= captured data and upd_strobe <= 1.
  - Else: no register changes and err <= 1.
  - In both cases: upd_addr <= captured address, ack <= 1, next state ACK.
- ACK (one cycle):
  - ack, upd_strobe and err are high during this cycle and are cleared at its end.
  - Next state RELEASE; counter <= 0.
- RELEASE:
  - If valid=0, next state IDLE.
  - Else counter increments; when counter == RELEASE_TIMEOUT-1 with valid still high, force IDLE.
  - A still-high valid in IDLE is then treated as a new command. This prevents deadlock if the decoder never drops valid.
- Latency:
  - valid sampled at edge N; register, upd_strobe, err and ack visible after edge N+1.
  - ack high for exactly the cycle between edges N+1 and N+2.
  - Total of 2 cycles from valid to ack, well inside the decoder's 8-cycle SEND window.
- Boundary conditions:
  - Writes to the same register back-to-back: the last write wins; each write gets its own ack and strobe.
  - Changes on address/data while not in IDLE are ignored; the captured values are used.
  - Writing data equal to the current value still pulses upd_strobe.
  - regs changes only in the WRITE→ACK edge; there is no combinational path from inputs to outputs.
  - Back-to-back throughput: minimum 4 cycles per command (IDLE, WRITE, ACK, RELEASE with valid low).
  - NUM_REGS=16: err can never assert.

Test Plan:
1. Reset then idle -> regs all 0, ack/upd_strobe/err 0; assert rst mid-ACK -> ack drops asynchronously, regs return to 0.
2. valid=1, address=4'h3, data=4'hA for 3 cycles then 0 -> ack one-cycle pulse 2 cycles after valid seen, regs[15:12]=4'hA, upd_strobe=1 same cycle as ack, upd_addr=3, other regs unchanged.
3. NUM_REGS=8, address=4'hC, data=4'h5 -> ack pulse, err pulse, upd_strobe=0, no register change, upd_addr=4'hC.
4. valid held high continuously with address=1, data=7 -> a write every RELEASE_TIMEOUT+3 = 7 cycles, ack pulses each time, FSM never stalls.
5. Two commands: (addr 2, data 4) then (addr 2, data 9), each held until ack -> two acks, two strobes, final regs[11:8]=9.
6. During WRITE/ACK change address to 5 -> write still goes to the originally captured address, reg 5 untouched.

Source files
------------

// File: rtl/config_register_file_if.sv
// Address/data/valid/ack link between the frame address decoder (master) and the
// configuration register file (slave), plus the register-bank and update outputs.
interface config_register_file_if #(
    parameter int unsigned NUM_REGS = 16
);
    logic [3:0]            address;
    logic [3:0]            data;
    logic                  valid;
    logic                  ack;
    logic [4*NUM_REGS-1:0] regs;
    logic                  upd_strobe;
    logic [3:0]            upd_addr;
    logic                  err;

    modport master (
        output address, data, valid,
        input  ack, regs, upd_strobe, upd_addr, err
    );

    modport slave (
        input  address, data, valid,
        output ack, regs, upd_strobe, upd_addr, err
    );
endinterface

// File: rtl/config_register_file.sv
// Configuration register file: captures decoder write commands into a bank of 4-bit
// registers and answers each with a one-cycle ack plus update strobe or error pulse.
module config_register_file #(
    parameter int unsigned NUM_REGS        = 16,
    parameter int unsigned RELEASE_TIMEOUT = 4,
    parameter logic [3:0]  RESET_VALUE     = 4'h0
) (
    input logic                   clk,
    input logic                   rst,
    config_register_file_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWrite, StAck, StRelease} state_e;

    localparam logic [3:0] TimeoutLast = 4'(RELEASE_TIMEOUT - 1);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [3:0]            addr_q;
    logic [3:0]            data_q;
    logic                  ack_q;
    logic                  strobe_q;
    logic                  err_q;
    logic [3:0]            upd_addr_q;
    logic [4*NUM_REGS-1:0] regs_q;
    logic                  mapped;

    assign mapped = (32'(addr_q) < NUM_REGS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            ack_q      <= 1'b0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            upd_addr_q <= '0;
            regs_q     <= {NUM_REGS{RESET_VALUE}};
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.valid) begin
                        addr_q  <= bus.address;
                        data_q  <= bus.data;
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == 4'(i)) begin
                            regs_q[4*i +: 4] <= data_q;
                        end
                    end
                    strobe_q   <= mapped;
                    err_q      <= ~mapped;
                    upd_addr_q <= addr_q;
                    ack_q      <= 1'b1;
                    state_q    <= StAck;
                end
                StAck: begin
                    ack_q    <= 1'b0;
                    strobe_q <= 1'b0;
                    err_q    <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StRelease;
                end
                StRelease: begin
                    // A decoder that never drops valid is released after the timeout;
                    // the still-high valid then starts a fresh command from idle.
                    if (!bus.valid || cnt_q == TimeoutLast) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.upd_strobe = strobe_q;
    assign bus.err        = err_q;
    assign bus.upd_addr   = upd_addr_q;
    assign bus.regs       = regs_q;

endmodule

// File: tb/tb_config_register_file.sv
// Self-checking bench: one 16-register and one 8-register instance driven in lockstep,
// with a scoreboard of expected writes checked at every ack.
module tb_config_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    config_register_file_if #(.NUM_REGS(16)) b16 ();
    config_register_file_if #(.NUM_REGS(8))  b8 ();

    assign b8.address = b16.address;
    assign b8.data    = b16.data;
    assign b8.valid   = b16.valid;

    config_register_file #(.NUM_REGS(16), .RELEASE_TIMEOUT(4), .RESET_VALUE(4'h0)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    config_register_file #(.NUM_REGS(8), .RELEASE_TIMEOUT(4), .RESET_VALUE(4'h0)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    typedef struct {
        logic [3:0] addr;
        logic [63:0] regs16;
        logic [31:0] regs8;
        logic        err8;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] data;
        logic [3:0] alt_addr;
        logic [3:0] alt_data;
        int         hold;
    } vec_t;

    exp_t       sbq[$];
    logic [3:0] m16 [16];
    logic [3:0] m8  [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 16; i++) m16[i] = 4'h0;
        for (int i = 0; i < 8; i++) m8[i] = 4'h0;
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [3:0] d, input int c);
        exp_t e;
        m16[a] = d;
        if (a < 4'd8) m8[a] = d;
        for (int i = 0; i < 16; i++) e.regs16[4*i +: 4] = m16[i];
        for (int i = 0; i < 8; i++) e.regs8[4*i +: 4] = m8[i];
        e.addr = a;
        e.err8 = (a >= 4'd8);
        e.cyc  = c;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (b16.ack) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 64'(b16.ack), 64'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ack8", 64'(b8.ack), 64'(1));
                    chk("strobe16", 64'(b16.upd_strobe), 64'(1));
                    chk("err16", 64'(b16.err), 64'(0));
                    chk("upd_addr16", 64'(b16.upd_addr), 64'(e.addr));
                    chk("regs16", b16.regs, e.regs16);
                    chk("strobe8", 64'(b8.upd_strobe), 64'(!e.err8));
                    chk("err8", 64'(b8.err), 64'(e.err8));
                    chk("upd_addr8", 64'(b8.upd_addr), 64'(e.addr));
                    chk("regs8", 64'(b8.regs), 64'(e.regs8));
                end
            end else begin
                chk("quiet", 64'({b8.ack, b16.upd_strobe, b16.err, b8.upd_strobe, b8.err}), 64'(0));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 30 && sbq.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain", 64'(sbq.size()), 64'(0));
    endtask

    task automatic run_cmd(input vec_t v);
        @(negedge clk);
        b16.address = v.addr;
        b16.data    = v.data;
        b16.valid   = 1'b1;
        expect_write(v.addr, v.data, cyc + 2);
        @(negedge clk);
        // Captured on the edge just passed; these changes must be ignored.
        b16.address = v.alt_addr;
        b16.data    = v.alt_data;
        repeat (v.hold - 1) @(negedge clk);
        b16.valid = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   c0;
        tbl[0] = '{4'h3, 4'hA, 4'h3, 4'hA, 3};
        tbl[1] = '{4'h2, 4'h4, 4'h2, 4'h4, 2};
        tbl[2] = '{4'h2, 4'h9, 4'h2, 4'h9, 2};
        tbl[3] = '{4'hC, 4'h5, 4'hC, 4'h5, 1};
        tbl[4] = '{4'h4, 4'h6, 4'h5, 4'hF, 2};
        tbl[5] = '{4'h4, 4'h6, 4'h4, 4'h6, 1};
        tbl[6] = '{4'hF, 4'h1, 4'h0, 4'h2, 4};
        tbl[7] = '{4'h7, 4'hE, 4'h7, 4'hE, 6};
        tbl[8] = '{4'h8, 4'h3, 4'h1, 4'h1, 1};
        tbl[9] = '{4'h0, 4'h5, 4'h0, 4'h5, 2};

        reset_model();
        b16.address = 4'h0;
        b16.data    = 4'h0;
        b16.valid   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_regs16", b16.regs, 64'(0));
        chk("rst_regs8", 64'(b8.regs), 64'(0));
        chk("rst_outs", 64'({b16.ack, b16.upd_strobe, b16.err, b16.upd_addr}), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

        // Valid held high: the timeout relaunches a write every 7 cycles.
        @(negedge clk);
        c0 = cyc;
        b16.address = 4'h1;
        b16.data    = 4'h7;
        b16.valid   = 1'b1;
        expect_write(4'h1, 4'h7, c0 + 2);
        expect_write(4'h1, 4'h7, c0 + 9);
        expect_write(4'h1, 4'h7, c0 + 16);
        repeat (16) @(negedge clk);
        b16.valid = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);

        // Asynchronous reset while ack is high.
        @(negedge clk);
        b16.address = 4'h3;
        b16.data    = 4'h5;
        b16.valid   = 1'b1;
        expect_write(4'h3, 4'h5, cyc + 2);
        for (int i = 0; i < 10 && !b16.ack; i++) begin
            @(negedge clk);
            #1;
        end
        chk("ack_before_rst", 64'(b16.ack), 64'(1));
        rst = 1'b1;
        #1;
        chk("rst_ack", 64'({b16.ack, b8.ack, b16.upd_strobe, b8.err}), 64'(0));
        chk("rst_mid_regs16", b16.regs, 64'(0));
        chk("rst_mid_regs8", 64'(b8.regs), 64'(0));
        chk("rst_mid_upd_addr", 64'(b16.upd_addr), 64'(0));
        reset_model();
        sbq.delete();
        b16.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd('{4'h6, 4'hB, 4'h6, 4'hB, 2});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
